uart_tx_frame_encoder: RTL

- Transmit-side counterpart of the UART command decoder: streams captured ADC samples from on-chip sample memory to the host PC over the UART TX byte interface.
- On a start pulse from the top-level FSM, it emits one framed packet: header, sample count, samples, checksum, trailer.
- Sits between the sample memory read port and the UART transmitter (uart_wdata/uart_wreq/uart_rdy).

---
 rtl/giraffe_pkg.sv | 23 ++
 rtl/uart_tx_frame_encoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/giraffe_pkg.sv
// Shared frame constants and TX encoder state encoding for the host UART link.
// Used by both the RX command decoder and the TX frame encoder.
package giraffe_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN0,
    ST_LEN1,
    ST_LEN2,
    ST_FETCH,
    ST_RDWAIT,
    ST_SEND,
    ST_CSUM,
    ST_TAIL
  } tx_state_t;

  localparam logic [7:0] FRAME_HDR      = 8'hA5;
  localparam logic [7:0] FRAME_TAIL     = 8'hA5 ^ 8'hFF;
  // header + 3 length bytes + checksum + trailer
  localparam int         FRAME_OVERHEAD = 6;

endpackage

// File: rtl/uart_tx_frame_encoder.sv
// Streams N ADC samples from sample memory to the UART TX as one framed packet:
// A5, LEN[23:16..7:0], samples, checksum, 5A. uart_wreq is a pure function of state.
module uart_tx_frame_encoder
  import giraffe_pkg::*;
#(
  parameter int         NUM_bit       = 6,
  parameter int         UART_NUM_DATA = 8,
  parameter int         ADDR_W        = 19,
  parameter int         LEN_W         = 24,
  parameter logic [7:0] HDR_BYTE      = FRAME_HDR,
  parameter logic [7:0] TAIL_BYTE     = FRAME_TAIL
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         num_samples,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [NUM_bit-1:0]       mem_rd_data,
  output logic [UART_NUM_DATA-1:0] uart_wdata,
  output logic                     uart_wreq,
  input  logic                     uart_rdy,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              byte_cnt
);

  tx_state_t                state_q, state_d;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         idx_q;
  logic [LEN_W-1:0]         idx_inc;
  logic [ADDR_W-1:0]        base_q;
  logic [UART_NUM_DATA-1:0] csum_q;
  logic [UART_NUM_DATA-1:0] sample_q;
  logic                     done_q;
  logic [31:0]              byte_cnt_q;
  logic                     accept;

  // idx never exceeds len_q, so this increment cannot wrap even at N = 2^LEN_W-1
  assign idx_inc = idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
  assign accept  = uart_wreq && uart_rdy;

  always_comb begin
    state_d     = state_q;
    uart_wreq   = 1'b0;
    uart_wdata  = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;

    case (state_q)
      ST_HDR: begin
        uart_wreq  = 1'b1;
        uart_wdata = HDR_BYTE;
        if (uart_rdy) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        uart_wreq  = 1'b1;
        uart_wdata = len_q[LEN_W-1 -: 8];
        if (uart_rdy) state_d = ST_LEN1;
      end
      ST_LEN1: begin
        uart_wreq  = 1'b1;
        uart_wdata = len_q[LEN_W-9 -: 8];
        if (uart_rdy) state_d = ST_LEN2;
      end
      ST_LEN2: begin
        uart_wreq  = 1'b1;
        uart_wdata = len_q[7:0];
        if (uart_rdy) state_d = (len_q == '0) ? ST_CSUM : ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_q + ADDR_W'(idx_q);
        state_d     = ST_RDWAIT;
      end
      ST_RDWAIT: state_d = ST_SEND;
      ST_SEND: begin
        uart_wreq  = 1'b1;
        uart_wdata = sample_q;
        if (uart_rdy) state_d = (idx_inc == len_q) ? ST_CSUM : ST_FETCH;
      end
      ST_CSUM: begin
        uart_wreq  = 1'b1;
        uart_wdata = csum_q;
        if (uart_rdy) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        uart_wreq  = 1'b1;
        uart_wdata = TAIL_BYTE;
        if (uart_rdy) state_d = ST_IDLE;
      end
      default: if (start) state_d = ST_HDR;
    endcase

    // abort overrides everything, including a coincident start
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      csum_q     <= '0;
      sample_q   <= '0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (!abort) begin
        if (state_q == ST_IDLE && start) begin
          len_q      <= num_samples;
          base_q     <= base_addr;
          idx_q      <= '0;
          csum_q     <= '0;
          byte_cnt_q <= '0;
        end
        if (state_q == ST_RDWAIT) sample_q <= UART_NUM_DATA'(mem_rd_data);
        if (accept) begin
          if (byte_cnt_q != 32'hFFFF_FFFF) byte_cnt_q <= byte_cnt_q + 32'd1;
          if (state_q inside {ST_LEN0, ST_LEN1, ST_LEN2, ST_SEND}) csum_q <= csum_q + uart_wdata;
          if (state_q == ST_SEND) idx_q <= idx_inc;
          if (state_q == ST_TAIL) done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign byte_cnt = byte_cnt_q;

endmodule
